// File: rtl/ossa_pkg.sv
// Shared defaults, FSM state encoding and lane helper for the OSSA skew feeder.
package ossa_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int DW_DEFAULT    = 8;
    localparam int K_DEFAULT     = 8;
    localparam int DRAIN_DEFAULT = N_DEFAULT + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } feeder_state_e;

    function automatic logic [DW_DEFAULT-1:0] lane_slice(
        input logic [N_DEFAULT*DW_DEFAULT-1:0] vec,
        input int                              lane
    );
        return vec[lane*DW_DEFAULT +: DW_DEFAULT];
    endfunction

endpackage

// File: rtl/ossa_skew_line.sv
// Zero-reset shift line of DEPTH stages; output is the oldest stage.
module ossa_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] line_p [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) line_p[s] <= '0;
        end else begin
            line_p[0] <= din;
            for (int s = 1; s < DEPTH; s++) line_p[s] <= line_p[s-1];
        end
    end

    assign dout = line_p[DEPTH-1];

endmodule

// File: rtl/ossa_skew_feeder.sv
// Skews A/B operand beats into a diagonal wavefront for the systolic array.
// Optional OSSA_FEEDER_AUTO_RD_EN adds a READ phase driving out_data_rd_en.
module ossa_skew_feeder
    import ossa_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DW    = DW_DEFAULT,
    parameter int K     = K_DEFAULT,
    parameter int DRAIN = DRAIN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*DW-1:0] a_vec_in,
    input  logic [N*DW-1:0] b_vec_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N*DW-1:0] a_lane_out,
    output logic [N*DW-1:0] b_lane_out,
    output logic          busy,
    output logic          frame_done
`ifdef OSSA_FEEDER_AUTO_RD_EN
    ,
    output logic          out_data_rd_en
`endif
);

    localparam int BW = $clog2(K + 1);
    localparam int CW = $clog2(DRAIN + 1);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_FEED  = 3'(FEED);
    localparam logic [2:0] S_FLUSH = 3'(FLUSH);
    localparam logic [2:0] S_DONE  = 3'(DONE);
`ifdef OSSA_FEEDER_AUTO_RD_EN
    localparam logic [2:0] S_READ  = 3'(READ);
    localparam int         RW      = $clog2(N + 1);

    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
`endif

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic          accept;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_FEED);
`ifdef OSSA_FEEDER_AUTO_RD_EN
    assign busy = (state_q == S_FEED) || (state_q == S_FLUSH) || (state_q == S_READ);
`else
    assign busy = (state_q == S_FEED) || (state_q == S_FLUSH);
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
`ifdef OSSA_FEEDER_AUTO_RD_EN
        rd_cnt_d    = rd_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (K == 1) begin
                        state_d     = S_FLUSH;
                        beat_cnt_d  = '0;
                        drain_cnt_d = '0;
                    end else begin
                        state_d    = S_FEED;
                        beat_cnt_d = BW'(1);
                    end
                end
            end
            S_FEED: begin
                if (accept) begin
                    if (beat_cnt_q == BW'(K - 1)) begin
                        state_d     = S_FLUSH;
                        beat_cnt_d  = '0;
                        drain_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (drain_cnt_q == CW'(DRAIN - 1)) begin
                    drain_cnt_d = '0;
`ifdef OSSA_FEEDER_AUTO_RD_EN
                    state_d  = S_READ;
                    rd_cnt_d = '0;
`else
                    state_d  = S_DONE;
`endif
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
`ifdef OSSA_FEEDER_AUTO_RD_EN
            S_READ: begin
                if (rd_cnt_q == RW'(N - 1)) begin
                    state_d  = S_DONE;
                    rd_cnt_d = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + RW'(1);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // frame_done and the read strobe are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            beat_cnt_q     <= '0;
            drain_cnt_q    <= '0;
            frame_done     <= 1'b0;
`ifdef OSSA_FEEDER_AUTO_RD_EN
            rd_cnt_q       <= '0;
            out_data_rd_en <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            drain_cnt_q    <= drain_cnt_d;
            frame_done     <= (state_d == S_DONE);
`ifdef OSSA_FEEDER_AUTO_RD_EN
            rd_cnt_q       <= rd_cnt_d;
            out_data_rd_en <= (state_d == S_READ);
`endif
        end
    end

    // Idle cycles push zeros so bubbles never contribute to the MAC sums
    for (genvar i = 0; i < N; i++) begin : g_lane
        ossa_skew_line #(.DEPTH(i + 1), .DW(DW)) u_a_line (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (accept ? a_vec_in[i*DW +: DW] : {DW{1'b0}}),
            .dout  (a_lane_out[i*DW +: DW])
        );
        ossa_skew_line #(.DEPTH(i + 1), .DW(DW)) u_b_line (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (accept ? b_vec_in[i*DW +: DW] : {DW{1'b0}}),
            .dout  (b_lane_out[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_ossa_skew_feeder.sv
// Self-checking bench for ossa_skew_feeder against a cycle-indexed reference model.
module tb_ossa_skew_feeder;
    import ossa_pkg::*;

    localparam int N     = N_DEFAULT;
    localparam int DW    = DW_DEFAULT;
    localparam int K     = K_DEFAULT;
    localparam int DRAIN = DRAIN_DEFAULT;
`ifdef OSSA_FEEDER_AUTO_RD_EN
    localparam int NR    = N;
`else
    localparam int NR    = 0;
`endif
    localparam int HIST  = 4096;
    localparam int VW    = N * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] a_vec_in = '0;
    logic [VW-1:0] b_vec_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] a_lane_out;
    logic [VW-1:0] b_lane_out;
    logic          busy;
    logic          frame_done;
    logic          rd_obs;

    ossa_skew_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_vec_in   (a_vec_in),
        .b_vec_in   (b_vec_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_lane_out (a_lane_out),
        .b_lane_out (b_lane_out),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef OSSA_FEEDER_AUTO_RD_EN
        ,
        .out_data_rd_en (rd_obs)
`endif
    );
`ifndef OSSA_FEEDER_AUTO_RD_EN
    assign rd_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: history of accepted beats indexed by edge number
    int            edge_n = 0;
    int            hist_start = 1;
    int            frame_beats = 0;
    int            last_e = -100000;
    bit            m_ready = 1'b1;
    bit            hv [HIST];
    logic [VW-1:0] ha [HIST];
    logic [VW-1:0] hb [HIST];
    logic [VW-1:0] la [HIST];
    logic [VW-1:0] lb [HIST];
    logic [VW-1:0] exp_a, exp_b;
    bit            exp_ready, exp_busy, exp_done, exp_rd;
    logic [VW-1:0] fa [$];
    logic [VW-1:0] fb [$];
    logic [VW-1:0] fr_a [K];
    logic [VW-1:0] fr_b [K];

    task automatic tick(input bit v, input logic [VW-1:0] a, input logic [VW-1:0] b);
        int c, win_end, idx;
        in_valid = v;
        a_vec_in = a;
        b_vec_in = b;
        @(posedge clk);
        edge_n++;
        c = edge_n;
        hv[c] = v && m_ready;
        ha[c] = a;
        hb[c] = b;
        if (hv[c]) begin
            fa.push_back(a);
            fb.push_back(b);
            frame_beats++;
            if (frame_beats == K) begin
                last_e = c;
                frame_beats = 0;
            end
        end
        win_end   = last_e + DRAIN + NR;
        exp_ready = !(c >= last_e && c <= win_end);
        exp_busy  = (frame_beats > 0) || (c >= last_e && c < win_end);
        exp_done  = (c == win_end);
        exp_rd    = (NR > 0) && (c >= last_e + DRAIN) && (c < win_end);
        m_ready   = exp_ready;
        for (int i = 0; i < N; i++) begin
            idx = c - i;
            exp_a[i*DW +: DW] = (idx >= hist_start && hv[idx]) ? lane_slice(ha[idx], i) : '0;
            exp_b[i*DW +: DW] = (idx >= hist_start && hv[idx]) ? lane_slice(hb[idx], i) : '0;
        end
        @(negedge clk);
        la[c] = a_lane_out;
        lb[c] = b_lane_out;
    endtask

    task automatic assert_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        hist_start = edge_n + 1;
        frame_beats = 0;
        last_e = -100000;
        m_ready = 1'b1;
        fa.delete();
        fb.delete();
    endtask

    function automatic logic [31:0] gold_c(int i, int j);
        logic [31:0] s = 0;
        for (int k = 0; k < fa.size(); k++)
            s += 32'(lane_slice(fa[k], i)) * 32'(lane_slice(fb[k], j));
        return s;
    endfunction

    // what PE(i,j) accumulates: A lane i delayed j, B lane j delayed i
    function automatic logic [31:0] dut_c(int s, int d, int i, int j);
        logic [31:0] acc = 0;
        for (int u = s; u <= d; u++)
            if (u + j - i >= s && u + j - i <= d)
                acc += 32'(la[u][i*DW +: DW]) * 32'(lb[u+j-i][j*DW +: DW]);
        return acc;
    endfunction

    task automatic rand_frame();
        for (int k = 0; k < K; k++) begin
            fr_a[k] = {$urandom, $urandom};
            fr_b[k] = {$urandom, $urandom};
        end
    endtask

    task automatic run_frame(input int gap_after, input int gap_len, input bit rand_gaps,
                             output int first_e, output int done_e, output int rd_count);
        int k, bub, guard;
        bit v, acc;
        logic [VW-1:0] a, b;
        k = 0; bub = gap_len; guard = 0;
        first_e = -1; done_e = -1; rd_count = 0;
        fa.delete();
        fb.delete();
        while (guard < 200 && done_e < 0) begin
            guard++;
            if (k < K) begin
                v = 1'b1;
                if (k == gap_after && bub > 0) begin
                    v = 1'b0;
                    bub--;
                end else if (rand_gaps && $urandom_range(0, 3) == 0) begin
                    v = 1'b0;
                end
                a = fr_a[k];
                b = fr_b[k];
            end else begin
                v = 1'($urandom);
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
            end
            acc = v && m_ready;
            tick(v, a, b);
            if (acc) begin
                if (first_e < 0) first_e = edge_n;
                k++;
            end
            n_checks++;
            if ({a_lane_out, b_lane_out, in_ready, busy, frame_done, rd_obs} !==
                {exp_a, exp_b, exp_ready, exp_busy, exp_done, exp_rd}) begin
                n_fail++;
                $display("FAIL cycle_%0d got a=%h b=%h rdy=%b busy=%b done=%b rd=%b required a=%h b=%h rdy=%b busy=%b done=%b rd=%b",
                         edge_n, a_lane_out, b_lane_out, in_ready, busy, frame_done, rd_obs,
                         exp_a, exp_b, exp_ready, exp_busy, exp_done, exp_rd);
            end
            if (rd_obs === 1'b1) rd_count++;
            if (frame_done === 1'b1) done_e = edge_n;
        end
        if (done_e < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout got none within %0d cycles required a pulse", guard);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({a_lane_out, b_lane_out, in_ready, busy, frame_done, rd_obs} !== {{(2*VW){1'b0}}, 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_hold got a=%h b=%h rdy=%b busy=%b done=%b required 0/0/1/0/0",
                     a_lane_out, b_lane_out, in_ready, busy, frame_done);
        end
        release_reset();
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            n_checks++;
            if ({a_lane_out, b_lane_out, in_ready, busy, frame_done, rd_obs} !== {{(2*VW){1'b0}}, 4'b1000}) begin
                n_fail++;
                $display("FAIL reset_idle_%0d got a=%h b=%h rdy=%b busy=%b done=%b rd=%b required 0/0/1/0/0/0",
                         c, a_lane_out, b_lane_out, in_ready, busy, frame_done, rd_obs);
            end
        end
    endtask

    task automatic test_single_beat();
        logic [VW-1:0] wa, wb;
        logic [VW-1:0] av, bv;
        av = 64'h0807060504030201;
        bv = 64'h1817161514131211;
        assert_reset();
        release_reset();
        for (int d = 0; d < 10; d++) begin
            if (d == 0) tick(1'b1, av, bv);
            else        tick(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            for (int i = 0; i < N; i++) begin
                wa[i*DW +: DW] = (d == i) ? 8'(i + 1)    : 8'h00;
                wb[i*DW +: DW] = (d == i) ? 8'(8'h11 + i) : 8'h00;
            end
            n_checks++;
            if (a_lane_out !== wa || b_lane_out !== wb || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL single_beat_d%0d got a=%h b=%h rdy=%b required a=%h b=%h rdy=1",
                         d, a_lane_out, b_lane_out, in_ready, wa, wb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fe, de, rc, bad;
        assert_reset();
        release_reset();
        rand_frame();
        run_frame(K, 0, 1'b0, fe, de, rc);
        n_checks++;
        if (de - fe !== K - 1 + DRAIN + NR) begin
            n_fail++;
            $display("FAIL b2b_done_latency got %0d required %0d", de - fe, K - 1 + DRAIN + NR);
        end
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (dut_c(fe, de, i, j) !== gold_c(i, j)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_matmul got %0d wrong elements required 0", bad);
        end
        n_checks++;
        if (rc !== NR) begin
            n_fail++;
            $display("FAIL rd_strobe_count got %0d required %0d", rc, NR);
        end
    endtask

    task automatic test_bubble();
        int fe, de, rc, bad;
        run_frame(4, 3, 1'b0, fe, de, rc);
        n_checks++;
        if (de - fe !== K - 1 + DRAIN + NR + 3) begin
            n_fail++;
            $display("FAIL bubble_done_latency got %0d required %0d", de - fe, K - 1 + DRAIN + NR + 3);
        end
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (dut_c(fe, de, i, j) !== gold_c(i, j)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bubble_matmul got %0d wrong elements required 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        int fe, de, rc, bad;
        rand_frame();
        for (int k = 0; k < 5; k++) tick(1'b1, fr_a[k], fr_b[k]);
        assert_reset();
        n_checks++;
        if ({a_lane_out, b_lane_out, in_ready, busy, frame_done} !== {{(2*VW){1'b0}}, 3'b100}) begin
            n_fail++;
            $display("FAIL mid_reset got a=%h b=%h rdy=%b busy=%b done=%b required 0/0/1/0/0",
                     a_lane_out, b_lane_out, in_ready, busy, frame_done);
        end
        release_reset();
        rand_frame();
        run_frame(K, 0, 1'b0, fe, de, rc);
        bad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (dut_c(fe, de, i, j) !== gold_c(i, j)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL post_reset_matmul got %0d wrong elements required 0", bad);
        end
    endtask

    task automatic test_random_frames();
        int fe, de, rc, bad;
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            run_frame(K, 0, 1'b1, fe, de, rc);
            bad = 0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (dut_c(fe, de, i, j) !== gold_c(i, j)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_frame_%0d_matmul got %0d wrong elements required 0", f, bad);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_bubble();
        test_mid_reset();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
